mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RISC-V lite pipeline. It consumes the EX/MEM pipeline register outputs (branch target, ALU result, store operand, zero flag) and resolves conditional branches. It performs loads and stores on the data memory through a req/ack handshake, stalling the pipeline while an access is outstanding. Results are captured into the MEM/WB pipeline registers.

## Interface
- N, 32, datapath width; only 32 is supported, since byte lanes assume 4 bytes/word.

Ports (clock and reset first):
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  reset; asynchronous, active-low.
- regEn  in  1  MEM/WB register enable from CU.
- NPCbranch  in  N  branch target from EX/MEM.
- ALUres  in  N  ALU result; the memory byte address for loads/stores.
- Bout  in  N  store data from EX/MEM.
- zero  in  1  ALU zero flag from EX/MEM.
- branch  in  1  conditional-branch instruction (CU).
- memRead  in  1  load instruction (CU).
- memWrite  in  1  store instruction (CU).
- lsSize  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- lsUnsigned  in  1  zero-extend loads when 1; sign-extend when 0.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  write strobe, registered.
- dmem_addr  out  N  word-aligned address {ALUres[N-1:2],2'b00}, registered.
- dmem_wdata  out  N  store data placed in its lanes, registered.
- dmem_be  out  4  byte enables, registered.
- dmem_ack  in  1  memory completes the access in this cycle.
- dmem_rdata  in  N  read word; valid when dmem_ack=1.
- PCsrc  out  1  branch taken = branch & zero; combinational.
- NPCout  out  N  NPCbranch passthrough; combinational.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; combinational from state.
- misalign  out  1  misaligned access flag, registered with MEM/WB.
- LMD  out  N  loaded data, MEM/WB register.
- ALUwb  out  N  ALUres, MEM/WB register.

## Operation
- access = memRead | memWrite. memRead and memWrite both high is treated as a store.
- Alignment:
  - half: misaligned if ALUres[0]=1.
  - word: misaligned if ALUres[1:0]≠0.
  - byte: never misaligned.
- FSM states: IDLE, REQ, DONE.
  - IDLE: if access & aligned, go to REQ. At that edge, load dmem_addr/we/wdata/be and set dmem_req=1. Otherwise stay in IDLE.
  - REQ: hold all dmem_* outputs stable. On dmem_ack=1: capture the extended read data into an internal load buffer, drop dmem_req, and go to DONE. Otherwise stay in REQ.
  - DONE: go to IDLE unconditionally. The same instruction is never re-issued.
- stall is 1 in IDLE when access & aligned, and 1 in REQ. It is 0 in DONE, and 0 in IDLE when there is no access or the access is misaligned.
- Store lanes, with off = ALUres[1:0]:
  - byte: be = 0001<<off; wdata = Bout[7:0] replicated ×4.
  - half: be = 0011<<off; wdata = Bout[15:0] replicated ×2.
  - word: be = 1111; wdata = Bout.
- Load extraction: take byte (rdata>>8·off)[7:0] or half (rdata>>8·off)[15:0], then sign- or zero-extend per lsUnsigned. Word loads pass rdata through.
- MEM/WB registers (LMD, ALUwb, misalign) load when regEn & ~stall:
  - LMD = load buffer for a completed load, else 0.
  - misalign = access & ~aligned.
- A misaligned access issues no request, produces no stall, is otherwise a no-op and sets misalign.
- PCsrc and NPCout are purely combinational. They are not gated by stall, because EX/MEM is frozen during a stall.

## Timing
- Reset (rst=0, asynchronous): state=IDLE and every registered output is 0, including dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, LMD, ALUwb and misalign. Reset during REQ abandons the access and drops dmem_req immediately.
- Request is valid from the edge that enters REQ; ack is sampled on the following edges.
- Minimum cost of a memory instruction: 2 stall cycles (IDLE-detect, REQ with same-cycle ack), then DONE with the MEM/WB load. Each cycle ack is withheld adds one stall cycle.
- Non-memory instructions: zero stall; MEM/WB loads on the next edge when regEn=1.
- regEn=0 in DONE: the FSM still returns to IDLE and the MEM/WB registers hold their value. The CU must not drop regEn during a memory access.

## Test plan
- Word load: ALUres=0x100, memRead, ack in the first REQ cycle, rdata=0xDEADBEEF → dmem_addr=0x100, be=1111, stall high for 2 cycles, then LMD=0xDEADBEEF and ALUwb=0x100.
- Signed byte load: ALUres=0x103, lsSize=00, rdata=0x80112233, with lsUnsigned=0 and then 1 → LMD=0xFFFFFF80, then LMD=0x00000080.
- Half store with ack delayed 3 cycles: ALUres=0x22, Bout=0x0000ABCD → be=1100, wdata=0xABCDABCD, dmem_* stable across the wait, stall high for 5 cycles.
- Misaligned word load at 0x102 → dmem_req never asserted, stall stays 0, misalign=1 and LMD=0 after the edge.
- Branch: branch=1, zero=1, NPCbranch=0x40 → PCsrc=1 and NPCout=0x40 in the same cycle; with zero=0, PCsrc=0.
- rst pulsed low while in REQ → dmem_req=0, stall=0 and all outputs 0 immediately. After release, the next instruction is processed from IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the RISC-V lite pipeline: branch resolve, data-memory req/ack
// access with pipeline stall, and the MEM/WB register set.
module mem_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         regEn,
   input  logic [N-1:0] NPCbranch,
   input  logic [N-1:0] ALUres,
   input  logic [N-1:0] Bout,
   input  logic         zero,
   input  logic         branch,
   input  logic         memRead,
   input  logic         memWrite,
   input  logic [1:0]   lsSize,
   input  logic         lsUnsigned,
   output logic         dmem_req,
   output logic         dmem_we,
   output logic [N-1:0] dmem_addr,
   output logic [N-1:0] dmem_wdata,
   output logic [3:0]   dmem_be,
   input  logic         dmem_ack,
   input  logic [N-1:0] dmem_rdata,
   output logic         PCsrc,
   output logic [N-1:0] NPCout,
   output logic         stall,
   output logic         misalign,
   output logic [N-1:0] LMD,
   output logic [N-1:0] ALUwb
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t       state;
   logic         access, is_load, aligned;
   logic [1:0]   off;
   logic [3:0]   be_n;
   logic [N-1:0] wdata_n, rsh, ldext, ldbuf;

   assign access  = memRead | memWrite;
   assign is_load = memRead & ~memWrite;
   assign off     = ALUres[1:0];
   assign PCsrc   = branch & zero;
   assign NPCout  = NPCbranch;

   // stall is forced low while reset is held so an abandoned access frees the pipe
   assign stall = rst & (((state == IDLE) & access & aligned) | (state == REQ));

   always_comb begin
      aligned = 1'b1;
      be_n    = 4'b1111;
      wdata_n = Bout;
      case (lsSize)
         2'b00: begin
            be_n    = 4'b0001 << off;
            wdata_n = {4{Bout[7:0]}};
         end
         2'b01: begin
            aligned = ~off[0];
            be_n    = 4'b0011 << off;
            wdata_n = {2{Bout[15:0]}};
         end
         default: aligned = (off == 2'b00);
      endcase
   end

   assign rsh = dmem_rdata >> {off, 3'b000};

   always_comb begin
      case (lsSize)
         2'b00:   ldext = {{(N-8){~lsUnsigned & rsh[7]}}, rsh[7:0]};
         2'b01:   ldext = {{(N-16){~lsUnsigned & rsh[15]}}, rsh[15:0]};
         default: ldext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= '0;
         ldbuf      <= '0;
      end else begin
         case (state)
            IDLE: if (access && aligned) begin
               state      <= REQ;
               dmem_req   <= 1'b1;
               dmem_we    <= memWrite;
               dmem_addr  <= {ALUres[N-1:2], 2'b00};
               dmem_wdata <= wdata_n;
               dmem_be    <= be_n;
            end
            REQ: if (dmem_ack) begin
               ldbuf    <= ldext;
               dmem_req <= 1'b0;
               state    <= DONE;
            end
            // EX/MEM advances on this edge, so the instruction is never re-issued
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         LMD      <= '0;
         ALUwb    <= '0;
         misalign <= 1'b0;
      end else if (regEn && !stall) begin
         LMD      <= ((state == DONE) && is_load) ? ldbuf : '0;
         ALUwb    <= ALUres;
         misalign <= access & ~aligned;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a reference model predicts each instruction's
// bus activity, stall length and MEM/WB result; a simple responder plays memory.
module tb_mem_stage;

   logic        clk, rst, regEn;
   logic [31:0] NPCbranch, ALUres, Bout;
   logic        zero, branch, memRead, memWrite;
   logic [1:0]  lsSize;
   logic        lsUnsigned;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        PCsrc;
   logic [31:0] NPCout;
   logic        stall, misalign;
   logic [31:0] LMD, ALUwb;

   mem_stage #(.N(32)) dut (
      .clk(clk), .rst(rst), .regEn(regEn), .NPCbranch(NPCbranch), .ALUres(ALUres),
      .Bout(Bout), .zero(zero), .branch(branch), .memRead(memRead), .memWrite(memWrite),
      .lsSize(lsSize), .lsUnsigned(lsUnsigned), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .PCsrc(PCsrc), .NPCout(NPCout),
      .stall(stall), .misalign(misalign), .LMD(LMD), .ALUwb(ALUwb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lmd;
      logic [31:0] aluwb;
      logic        mis;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          nstall;
   } exp_t;

   exp_t sb[$];
   int nchk = 0;
   int nerr = 0;
   int last_nstall;
   logic [3:0]  last_be;
   logic [31:0] last_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic rd, input logic wr, input logic [1:0] sz,
                                  input logic uns, input int dly, input logic [31:0] rdata);
      exp_t e;
      logic [1:0]  s, o;
      logic [7:0]  by;
      logic [15:0] hw;
      logic        acc;
      s   = (sz == 2'd3) ? 2'd2 : sz;
      o   = a[1:0];
      acc = rd | wr;
      e.mis   = acc && ((s == 2'd1 && o[0]) || (s == 2'd2 && o != 2'd0));
      e.aluwb = a;
      e.addr  = a & 32'hFFFF_FFFC;
      e.nstall = (acc && !e.mis) ? 2 + dly : 0;
      case (s)
         2'd0:    begin e.be = 4'b0001 << o; e.wdata = {b[7:0], b[7:0], b[7:0], b[7:0]}; end
         2'd1:    begin e.be = (o == 2'd0) ? 4'b0011 : 4'b1100; e.wdata = {b[15:0], b[15:0]}; end
         default: begin e.be = 4'b1111; e.wdata = b; end
      endcase
      e.lmd = 32'h0;
      if (rd && !wr && !e.mis) begin
         by = rdata[8*o +: 8];
         case (s)
            2'd0: e.lmd = uns ? {24'h0, by} : {{24{by[7]}}, by};
            2'd1: begin
               hw = rdata[8*o +: 16];
               e.lmd = uns ? {16'h0, hw} : {{16{hw[15]}}, hw};
            end
            default: e.lmd = rdata;
         endcase
      end
      return e;
   endfunction

   task automatic exec(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input int dly, input logic [31:0] rdata);
      exp_t e, got;
      int n, w;
      e = model(a, b, rd, wr, sz, uns, dly, rdata);
      sb.push_back(e);
      @(negedge clk);
      ALUres = a; Bout = b; memRead = rd; memWrite = wr; lsSize = sz; lsUnsigned = uns;
      regEn = 1'b1; dmem_ack = 1'b0;
      #1;
      chk({tag, "_req_idle"}, {31'b0, dmem_req}, 32'h0);
      n = 0; w = 0;
      while (stall && n < 40) begin
         n++;
         if (dmem_req) begin
            chk({tag, "_addr"}, dmem_addr, e.addr);
            chk({tag, "_be"}, {28'b0, dmem_be}, {28'b0, e.be});
            chk({tag, "_we"}, {31'b0, dmem_we}, {31'b0, wr});
            if (wr) chk({tag, "_wdata"}, dmem_wdata, e.wdata);
            last_be = dmem_be; last_wdata = dmem_wdata;
            dmem_ack = (w == dly);
            dmem_rdata = (w == dly) ? rdata : 32'hBAD0_BAD0;
            w++;
         end
         @(negedge clk);
         dmem_ack = 1'b0;
         #1;
      end
      last_nstall = n;
      chk({tag, "_nstall"}, n, e.nstall);
      chk({tag, "_req_done"}, {31'b0, dmem_req}, 32'h0);
      @(posedge clk);
      #1;
      chk({tag, "_sb_size"}, sb.size(), 1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         chk({tag, "_LMD"}, LMD, got.lmd);
         chk({tag, "_ALUwb"}, ALUwb, got.aluwb);
         chk({tag, "_mis"}, {31'b0, misalign}, {31'b0, got.mis});
      end
   endtask

   initial begin
      rst = 1'b0; regEn = 1'b0; NPCbranch = '0; ALUres = '0; Bout = '0; zero = 1'b0;
      branch = 1'b0; memRead = 1'b0; memWrite = 1'b0; lsSize = 2'b10; lsUnsigned = 1'b0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      #12;
      chk("rst_req", {31'b0, dmem_req}, 32'h0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_LMD", LMD, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      exec("wload", 32'h100, 32'h0, 1, 0, 2'b10, 0, 0, 32'hDEADBEEF);
      chk("wload_LMD_k", LMD, 32'hDEADBEEF);
      chk("wload_ALUwb_k", ALUwb, 32'h100);
      chk("wload_stall_k", last_nstall, 2);
      chk("wload_be_k", {28'b0, last_be}, 32'hF);

      exec("sbyte", 32'h103, 32'h0, 1, 0, 2'b00, 0, 0, 32'h80112233);
      chk("sbyte_LMD_k", LMD, 32'hFFFFFF80);
      exec("ubyte", 32'h103, 32'h0, 1, 0, 2'b00, 1, 0, 32'h80112233);
      chk("ubyte_LMD_k", LMD, 32'h00000080);

      exec("hstore", 32'h22, 32'h0000ABCD, 0, 1, 2'b01, 0, 3, 32'h0);
      chk("hstore_be_k", {28'b0, last_be}, 32'hC);
      chk("hstore_wdata_k", last_wdata, 32'hABCDABCD);
      chk("hstore_stall_k", last_nstall, 5);

      exec("miswl", 32'h102, 32'h0, 1, 0, 2'b10, 0, 0, 32'h12345678);
      chk("miswl_mis_k", {31'b0, misalign}, 32'h1);
      chk("miswl_LMD_k", LMD, 32'h0);

      exec("nomem", 32'h5555, 32'h0, 0, 0, 2'b10, 0, 0, 32'h0);
      exec("rdwr", 32'h44, 32'h11223344, 1, 1, 2'b11, 0, 1, 32'hFFFFFFFF);

      @(negedge clk);
      branch = 1'b1; zero = 1'b1; NPCbranch = 32'h40;
      #1;
      chk("br_taken", {31'b0, PCsrc}, 32'h1);
      chk("br_npc", NPCout, 32'h40);
      zero = 1'b0;
      #1;
      chk("br_not", {31'b0, PCsrc}, 32'h0);
      branch = 1'b0;

      // reset while an access is outstanding
      @(negedge clk);
      ALUres = 32'h200; memRead = 1'b1; memWrite = 1'b0; lsSize = 2'b10; dmem_ack = 1'b0;
      @(negedge clk);
      #1;
      chk("rreq_req", {31'b0, dmem_req}, 32'h1);
      rst = 1'b0;
      #1;
      chk("rreq_req0", {31'b0, dmem_req}, 32'h0);
      chk("rreq_stall0", {31'b0, stall}, 32'h0);
      chk("rreq_addr0", dmem_addr, 32'h0);
      chk("rreq_ALUwb0", ALUwb, 32'h0);
      chk("rreq_be0", {28'b0, dmem_be}, 32'h0);
      memRead = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exec("postrst", 32'h204, 32'h0, 1, 0, 2'b01, 1, 1, 32'h9876FEDC);
      chk("postrst_LMD_k", LMD, 32'h0000FEDC);

      for (int i = 0; i < 24; i++) begin
         logic [1:0] op;
         op = 2'($urandom_range(0, 3));
         exec("rnd", 32'h1000 + $urandom_range(0, 255), $urandom, op[0], op[1],
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
